// File: rtl/johnson_pkg.sv
// Shared types, default sizes and Johnson-pattern helpers for the sequencer.
package johnson_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;
  localparam int MAX_WIDTH = 32;

  // i-th pattern of the forward Johnson sequence starting at all-zero:
  // fill with ones from the LSB, then drain them from the LSB.
  function automatic logic [MAX_WIDTH-1:0] johnson_pattern(input int idx, input int width);
    logic [63:0] ones;
    ones = (64'd1 << width) - 64'd1;
    if (idx <= width)
      johnson_pattern = MAX_WIDTH'((64'd1 << idx) - 64'd1);
    else
      johnson_pattern = MAX_WIDTH'((ones << (idx - width)) & ones);
  endfunction

  // True when value is one of the 2*width patterns of the sequence.
  function automatic logic is_legal(input logic [MAX_WIDTH-1:0] value, input int width);
    is_legal = 1'b0;
    for (int i = 0; i < 2 * MAX_WIDTH; i++) begin
      if (i < 2 * width && value == johnson_pattern(i, width))
        is_legal = 1'b1;
    end
  endfunction

endpackage

// File: rtl/johnson_core.sv
// Johnson shift register with clear, advance and direction controls.
module johnson_core
  import johnson_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             advance,
  input  logic             dir,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;

  // Next value: clear beats advance; dir=1 walks the sequence backwards.
  always_comb begin
    count_next = count_reg;
    if (clear)
      count_next = '0;
    else if (advance) begin
      if (dir)
        count_next = {~count_reg[0], count_reg[WIDTH-1:1]};
      else
        count_next = {count_reg[WIDTH-2:0], ~count_reg[WIDTH-1]};
    end
  end

  // Register update with asynchronous clear to the first pattern.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      count_reg <= '0;
    else
      count_reg <= count_next;
  end

  assign count = count_reg;

endmodule

// File: rtl/johnson_seq_ctrl.sv
// Run/step controller around a Johnson counter with one-hot phase decode
// and a sticky illegal-pattern flag.
module johnson_seq_ctrl
  import johnson_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic               stop,
  input  logic               dir,
  input  logic [CNT_W-1:0]   num_steps,
  input  logic               step,
  output logic [WIDTH-1:0]   count,
  output logic [2*WIDTH-1:0] phase,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] remaining_reg, remaining_next;
  logic             dir_reg, dir_next;
  logic             done_reg;
  logic             err_reg;
  logic             illegal;
  logic             core_advance;
  logic             core_dir;
  logic             core_clear;

  johnson_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .n_rst   (n_rst),
    .advance (core_advance),
    .dir     (core_dir),
    .clear   (core_clear),
    .count   (count)
  );

  assign illegal = !is_legal(MAX_WIDTH'(count), WIDTH);

  // One-hot phase decode, one comparator per sequence position.
  for (genvar gi = 0; gi < 2 * WIDTH; gi++) begin : g_phase
    assign phase[gi] = (MAX_WIDTH'(count) == johnson_pattern(gi, WIDTH));
  end

  // Next-state and counter controls; an illegal pattern overrides everything.
  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    dir_next       = dir_reg;
    core_advance   = 1'b0;
    core_dir       = dir_reg;
    core_clear     = 1'b0;
    if (illegal) begin
      core_clear = 1'b1;
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start && stop) begin
            state_next = IDLE;
          end else if (start) begin
            remaining_next = num_steps;
            dir_next       = dir;
            state_next     = RUN;
          end else if (step) begin
            core_advance = 1'b1;
            core_dir     = dir;
          end
        end
        RUN: begin
          if (stop) begin
            state_next = DONE;
          end else begin
            core_advance = 1'b1;
            // A latched zero never decrements, so it means run until stop.
            if (remaining_reg == CNT_W'(1)) begin
              remaining_next = '0;
              state_next     = DONE;
            end else if (remaining_reg != '0) begin
              remaining_next = remaining_reg - CNT_W'(1);
            end
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Controller state, latched run parameters, done pulse and sticky error.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
      dir_reg       <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      dir_reg       <= dir_next;
      done_reg      <= (state_next == DONE);
      err_reg       <= err_reg | illegal;
    end
  end

  assign busy = (state_reg != IDLE);
  assign done = done_reg;
  assign err  = err_reg;

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Directed and randomized checks of johnson_seq_ctrl against an index-based model.
module tb_johnson_seq_ctrl;

  localparam int W  = 4;
  localparam int CW = 8;
  localparam int NP = 2 * W;

  logic            clk = 1'b0;
  logic            n_rst;
  logic            start, stop, dir, step;
  logic [CW-1:0]   num_steps;
  logic [W-1:0]    count;
  logic [2*W-1:0]  phase;
  logic            busy, done, err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: position in the forward sequence plus run bookkeeping.
  int m_idx, m_mode, m_rem, m_dir, m_err, m_bad;  // m_mode: 0 idle, 1 run, 2 done

  johnson_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .stop      (stop),
    .dir       (dir),
    .num_steps (num_steps),
    .step      (step),
    .count     (count),
    .phase     (phase),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Pattern at index i: i ones from the bottom, or all ones minus (i-W) low ones.
  function automatic int pat(input int i);
    if (i <= W) return (2 ** i) - 1;
    return ((2 ** W) - 1) - ((2 ** (i - W)) - 1);
  endfunction

  function automatic int move(input int i, input int d);
    return d ? (i + NP - 1) % NP : (i + 1) % NP;
  endfunction

  task automatic model_reset();
    m_idx = 0; m_mode = 0; m_rem = 0; m_dir = 0; m_err = 0; m_bad = 0;
  endtask

  task automatic model_edge(input logic s, input logic p, input logic st, input logic d, input int n);
    if (m_bad) begin
      m_err = 1; m_idx = 0; m_mode = 0; m_bad = 0;
    end else if (m_mode == 0) begin
      if (s && p) begin end
      else if (s) begin m_rem = n; m_dir = d; m_mode = 1; end
      else if (st) m_idx = move(m_idx, d);
    end else if (m_mode == 1) begin
      if (p) m_mode = 2;
      else begin
        m_idx = move(m_idx, m_dir);
        if (m_rem > 0) begin
          m_rem--;
          if (m_rem == 0) m_mode = 2;
        end
      end
    end else begin
      m_mode = 0;
    end
  endtask

  task automatic check_outputs(input string ctx);
    check_val({ctx, ":count"}, 32'(count), 32'(pat(m_idx)));
    check_val({ctx, ":phase"}, 32'(phase), 32'(1) << m_idx);
    check_val({ctx, ":busy"},  32'(busy),  32'(m_mode != 0));
    check_val({ctx, ":done"},  32'(done),  32'(m_mode == 2));
    check_val({ctx, ":err"},   32'(err),   32'(m_err));
  endtask

  // One clock: drive at negedge time, model the edge, sample 1 time unit later.
  task automatic tick(input string ctx, input logic s, input logic p, input logic st,
                      input logic d, input int n);
    start = s; stop = p; step = st; dir = d; num_steps = CW'(n);
    @(posedge clk);
    cyc++;
    model_edge(s, p, st, d, n);
    #1;
    $display("cyc %0d %s start=%b stop=%b step=%b dir=%b n=%0d count=%b busy=%b done=%b err=%b",
             cyc, ctx, s, p, st, d, n, count, busy, done, err);
    check_outputs(ctx);
    @(negedge clk);
  endtask

  initial begin
    n_rst = 1'b0; start = 0; stop = 0; step = 0; dir = 0; num_steps = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_outputs("reset");
    @(negedge clk);
    n_rst = 1'b1;

    // Five forward advances, done once, then idle.
    tick("run5_go", 1, 0, 0, 0, 5);
    for (int i = 0; i < 7; i++) tick("run5", 0, 0, 0, 1, 0);

    // Continuous reverse run stopped after ten advances.
    tick("cont_go", 1, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) tick("cont", 0, 0, 0, 0, 0);
    tick("cont_stop", 0, 1, 0, 0, 0);
    tick("cont_after", 0, 0, 0, 0, 0);
    tick("cont_after", 0, 0, 0, 0, 0);

    // Back to zero, then three forward steps.
    n_rst = 1'b0; model_reset(); #1 check_outputs("rst2"); @(negedge clk); n_rst = 1'b1;
    for (int i = 0; i < 3; i++) tick("step", 0, 0, 1, 0, 0);
    check_val("step3_count", 32'(count), 32'h7);

    // start+stop together stays idle; start while running is ignored.
    tick("start_stop", 1, 1, 0, 0, 4);
    tick("run3_go", 1, 0, 0, 0, 3);
    tick("run3", 1, 0, 1, 1, 6);
    for (int i = 0; i < 4; i++) tick("run3", i[0], 0, 0, 0, 2);
    tick("start_step", 1, 0, 1, 0, 1);
    tick("start_step_run", 0, 0, 0, 0, 0);
    tick("start_step_done", 0, 0, 0, 0, 0);

    // Illegal pattern: err next edge, count cleared, sticky until reset.
    force dut.u_core.count_reg = 4'b0101;
    #1 release dut.u_core.count_reg;
    #1;
    check_val("illegal_phase", 32'(phase), 32'h0);
    check_val("illegal_count", 32'(count), 32'h5);
    m_bad = 1;
    tick("illegal_edge", 0, 0, 0, 0, 0);
    tick("err_hold", 1, 0, 0, 0, 2);
    for (int i = 0; i < 3; i++) tick("err_hold", 0, 0, 0, 0, 0);
    n_rst = 1'b0; model_reset(); #1 check_outputs("err_clear"); @(negedge clk); n_rst = 1'b1;

    // Reset in the middle of a 20-step run: immediate clear, no done.
    tick("abort_go", 1, 0, 0, 0, 20);
    for (int i = 0; i < 7; i++) tick("abort_run", 0, 0, 0, 0, 0);
    n_rst = 1'b0; model_reset();
    #1 check_outputs("abort_rst");
    @(negedge clk); n_rst = 1'b1;
    for (int i = 0; i < 3; i++) tick("abort_after", 0, 0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      tick("rand", ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), $urandom_range(0, 6));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
